microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Generates the 10-bit microinstruction address for the registered 1024x44 decode ROM: one microinstruction per clock, with fetch/dispatch, continuation-page jumps, memory-wait stalls, halt, interrupt entry and overflow trap.
- Address format is {page[7:0], step[1:0]}. Each page holds up to 4 microsteps.
- Sits between the instruction register/memory interface and the decode ROM.
- The current control word v[43:0] is fed back in to choose the next address.

Parameters:
- FETCH_PAGE, 8'h00: page holding the fetch routine.
- IRQ_PAGE, 8'hFE: interrupt entry page.
- TRAP_PAGE, 8'hFF: page entered on step overflow or illegal dispatch.
- END_BIT, 43: control-word bit; end of routine.
- JUMP_BIT, 42: control-word bit; jump to continuation page.
- WAIT_BIT, 41: control-word bit; stall until mem_ready.
- HALT_BIT, 40: control-word bit; halt.
- JPAGE_LSB, 0: LSB of the 8-bit jump-page field in the control word.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-low.
- cw  in  44  current control word from the decode ROM (its v output).
- ir_opcode  in  8  opcode from the instruction register; valid when fetch ends.
- mem_ready  in  1  memory completed the current access.
- irq  in  1  level interrupt request.
- int_en  in  1  interrupts enabled.
- resume  in  1  leave the halted state.
- addr  out  10  next microaddress; drives the ROM addr input; combinational.
- cw_valid  out  1  cw is current and not stalled; datapath strobes are qualified by this.
- instr_done  out  1  one-cycle pulse when a non-fetch routine ends.
- irq_ack  out  1  one-cycle pulse when the interrupt page is entered.
- halted  out  1  sequencer is in HALT.
- fault  out  1  sticky flag for overflow or illegal dispatch.

Behaviour:
- Registers: state, page, step, fault.
- The ROM registers addr on the same edge that page/step update, so cw always corresponds to the current {page,step}.

States:
- PRIME: first cycle after reset. cw is invalid and is ignored. addr = {FETCH_PAGE,2'd0}. cw_valid = 0. Next state is RUN.
- RUN: cw is interpreted. cw_valid = 1 except in stall cycles.
- HALT: addr = {page,step}, so the ROM re-reads the same word. cw_valid = 0. halted = 1. On resume: page = FETCH_PAGE, step = 0, next state RUN.

Reset (rst low, asynchronous):
- state = PRIME, page = FETCH_PAGE, step = 0, fault = 0.
- All pulse outputs 0, cw_valid = 0, halted = 0, addr = {FETCH_PAGE,0}.
- Reset mid-instruction abandons the instruction. No instr_done is emitted.

RUN next-address priority (highest first):
1. Stall: cw[WAIT_BIT] && !mem_ready. addr = {page,step}, cw_valid = 0, no other action.
2. Halt: cw[HALT_BIT]. Next state HALT; addr holds.
3. End: cw[END_BIT]. Step resets to 0; the next page is chosen as follows.
   - Current page == FETCH_PAGE: next page = ir_opcode. If ir_opcode ∈ {FETCH_PAGE, IRQ_PAGE, TRAP_PAGE}, next page = TRAP_PAGE and fault is set instead.
   - Otherwise: pulse instr_done. If irq && int_en, next page = IRQ_PAGE and pulse irq_ack; else next page = FETCH_PAGE.
4. Jump: cw[JUMP_BIT]. page = cw[JPAGE_LSB+:8], step = 0.
5. Otherwise: step + 1. If step == 3 (overflow), page = TRAP_PAGE, step = 0, set fault.
- When END and JUMP are both set, END wins.
- Interrupts are sampled only at the end of a non-fetch routine. They are never taken mid-instruction or during fetch.
- fault clears only on reset. The trap routine then runs normally.
- Latency: addr presented in cycle n gives cw in cycle n+1. A stall adds one cycle per cycle that mem_ready is low.

Decomposition:
- Package scp_useq_pkg holds:
  - state encodings (PRIME, RUN, HALT);
  - default bit-position and page constants;
  - the address width (10) and step width (2).
- One combinational sub-module, useq_next_addr, implements the priority chain. Its outputs are next page, step, state and the pulse requests.
- The top level holds the registers and the reset logic.

Test Plan:
- Reset release: hold rst low for 3 cycles, then release. Required: addr = 10'h000 in PRIME, cw_valid = 0 for the first cycle, cw_valid = 1 from the next.
- Dispatch and retire:
  - Fetch page steps 0→1 then END, with ir_opcode = 8'h12. Required: addr = 10'h048.
  - Page 0x12 ends at step 2. Required: instr_done pulses for one cycle, then addr = 10'h000.
- Stall:
  - At page 0x12 step 1, set WAIT and hold mem_ready = 0 for 3 cycles. Required: addr holds at 10'h049 and cw_valid = 0 for 3 cycles.
  - Raise mem_ready. Required: addr = 10'h04A.
- Jump, then overflow:
  - JUMP with page field 8'h80 from page 0x12 step 3. Required: addr = 10'h200.
  - Page 0x80 runs steps 0–3 with no END/JUMP. Required: addr = 10'h3FC and fault = 1.
- Interrupt: irq = 1, int_en = 1 while page 0x12 hits END. Required: instr_done and irq_ack pulse together, addr = 10'h3F8. With int_en = 0, addr = 10'h000.
- Halt:
  - HALT and END asserted together. Required: halted = 1 and addr held.
  - Pulse resume. Required: addr = 10'h000, halted = 0.
  - Assert rst low while halted. Required: immediate return to PRIME.

Source files
------------

// File: rtl/scp_useq_pkg.sv
// Shared constants for the microcode sequencer.
// Address is {page, step}; cw is the registered decode ROM word.
package scp_useq_pkg;

    localparam int ADDR_W = 10;
    localparam int PAGE_W = 8;
    localparam int STEP_W = 2;
    localparam int CW_W   = 44;

    localparam logic [1:0] ST_PRIME = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [PAGE_W-1:0] DEF_FETCH_PAGE = 8'h00;
    localparam logic [PAGE_W-1:0] DEF_IRQ_PAGE   = 8'hFE;
    localparam logic [PAGE_W-1:0] DEF_TRAP_PAGE  = 8'hFF;

    localparam int DEF_END_BIT   = 43;
    localparam int DEF_JUMP_BIT  = 42;
    localparam int DEF_WAIT_BIT  = 41;
    localparam int DEF_HALT_BIT  = 40;
    localparam int DEF_JPAGE_LSB = 0;

    localparam logic [STEP_W-1:0] STEP_LAST = 2'd3;

endpackage

// File: rtl/useq_next_addr.sv
// Next-microaddress priority chain: stall, halt, end, jump, step.
// Purely combinational; the top registers its page/step/state.
module useq_next_addr
    import scp_useq_pkg::*;
#(
    parameter logic [PAGE_W-1:0] FETCH_PAGE = DEF_FETCH_PAGE,
    parameter logic [PAGE_W-1:0] IRQ_PAGE   = DEF_IRQ_PAGE,
    parameter logic [PAGE_W-1:0] TRAP_PAGE  = DEF_TRAP_PAGE,
    parameter int END_BIT   = DEF_END_BIT,
    parameter int JUMP_BIT  = DEF_JUMP_BIT,
    parameter int WAIT_BIT  = DEF_WAIT_BIT,
    parameter int HALT_BIT  = DEF_HALT_BIT,
    parameter int JPAGE_LSB = DEF_JPAGE_LSB
) (
    input  logic [1:0]        state,
    input  logic [PAGE_W-1:0] page,
    input  logic [STEP_W-1:0] step,
    input  logic [CW_W-1:0]   cw,
    input  logic [PAGE_W-1:0] ir_opcode,
    input  logic              mem_ready,
    input  logic              irq,
    input  logic              int_en,
    input  logic              resume,
    output logic [1:0]        nxt_state,
    output logic [PAGE_W-1:0] nxt_page,
    output logic [STEP_W-1:0] nxt_step,
    output logic              cw_ok,
    output logic              set_fault,
    output logic              done_req,
    output logic              ack_req
);

    logic bad_op;
    logic unused_cw;

    // Only a few control bits steer sequencing; the rest feed the datapath.
    assign unused_cw = ^cw;

    // Opcodes that would land on a reserved page are illegal dispatches.
    assign bad_op = (ir_opcode == FETCH_PAGE) ||
                    (ir_opcode == IRQ_PAGE) ||
                    (ir_opcode == TRAP_PAGE);

    // Select next page/step/state from the current word and mode.
    always_comb begin
        nxt_state = state;
        nxt_page  = page;
        nxt_step  = step;
        cw_ok     = 1'b0;
        set_fault = 1'b0;
        done_req  = 1'b0;
        ack_req   = 1'b0;
        unique case (state)
            ST_PRIME: begin
                nxt_state = ST_RUN;
                nxt_page  = FETCH_PAGE;
                nxt_step  = '0;
            end
            ST_HALT: begin
                if (resume) begin
                    nxt_state = ST_RUN;
                    nxt_page  = FETCH_PAGE;
                    nxt_step  = '0;
                end
            end
            ST_RUN: begin
                if (!(cw[WAIT_BIT] && !mem_ready)) begin
                    cw_ok = 1'b1;
                    if (cw[HALT_BIT]) begin
                        nxt_state = ST_HALT;
                    end else if (cw[END_BIT]) begin
                        nxt_step = '0;
                        if (page == FETCH_PAGE) begin
                            if (bad_op) begin
                                nxt_page  = TRAP_PAGE;
                                set_fault = 1'b1;
                            end else begin
                                nxt_page = ir_opcode;
                            end
                        end else begin
                            done_req = 1'b1;
                            if (irq && int_en) begin
                                nxt_page = IRQ_PAGE;
                                ack_req  = 1'b1;
                            end else begin
                                nxt_page = FETCH_PAGE;
                            end
                        end
                    end else if (cw[JUMP_BIT]) begin
                        nxt_page = cw[JPAGE_LSB +: PAGE_W];
                        nxt_step = '0;
                    end else if (step == STEP_LAST) begin
                        nxt_page  = TRAP_PAGE;
                        nxt_step  = '0;
                        set_fault = 1'b1;
                    end else begin
                        nxt_step = step + 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = ST_PRIME;
                nxt_page  = FETCH_PAGE;
                nxt_step  = '0;
            end
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: holds page/step/state/fault registers.
// addr is the next {page,step}; the ROM latches it with our regs.
module microcode_sequencer
    import scp_useq_pkg::*;
#(
    parameter logic [PAGE_W-1:0] FETCH_PAGE = DEF_FETCH_PAGE,
    parameter logic [PAGE_W-1:0] IRQ_PAGE   = DEF_IRQ_PAGE,
    parameter logic [PAGE_W-1:0] TRAP_PAGE  = DEF_TRAP_PAGE,
    parameter int END_BIT   = DEF_END_BIT,
    parameter int JUMP_BIT  = DEF_JUMP_BIT,
    parameter int WAIT_BIT  = DEF_WAIT_BIT,
    parameter int HALT_BIT  = DEF_HALT_BIT,
    parameter int JPAGE_LSB = DEF_JPAGE_LSB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   cw,
    input  logic [PAGE_W-1:0] ir_opcode,
    input  logic              mem_ready,
    input  logic              irq,
    input  logic              int_en,
    input  logic              resume,
    output logic [ADDR_W-1:0] addr,
    output logic              cw_valid,
    output logic              instr_done,
    output logic              irq_ack,
    output logic              halted,
    output logic              fault
);

    logic [1:0]        state;
    logic [PAGE_W-1:0] page;
    logic [STEP_W-1:0] step;
    logic [1:0]        nxt_state;
    logic [PAGE_W-1:0] nxt_page;
    logic [STEP_W-1:0] nxt_step;
    logic              set_fault;

    useq_next_addr #(
        .FETCH_PAGE (FETCH_PAGE),
        .IRQ_PAGE   (IRQ_PAGE),
        .TRAP_PAGE  (TRAP_PAGE),
        .END_BIT    (END_BIT),
        .JUMP_BIT   (JUMP_BIT),
        .WAIT_BIT   (WAIT_BIT),
        .HALT_BIT   (HALT_BIT),
        .JPAGE_LSB  (JPAGE_LSB)
    ) u_next (
        .state      (state),
        .page       (page),
        .step       (step),
        .cw         (cw),
        .ir_opcode  (ir_opcode),
        .mem_ready  (mem_ready),
        .irq        (irq),
        .int_en     (int_en),
        .resume     (resume),
        .nxt_state  (nxt_state),
        .nxt_page   (nxt_page),
        .nxt_step   (nxt_step),
        .cw_ok      (cw_valid),
        .set_fault  (set_fault),
        .done_req   (instr_done),
        .ack_req    (irq_ack)
    );

    assign addr   = {nxt_page, nxt_step};
    assign halted = (state == ST_HALT);

    // Track the ROM's address; fault is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_PRIME;
            page  <= FETCH_PAGE;
            step  <= '0;
            fault <= 1'b0;
        end else begin
            state <= nxt_state;
            page  <= nxt_page;
            step  <= nxt_step;
            if (set_fault) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed plan then random cycles.
// Expected values come from an address-arithmetic reference model.
module tb_microcode_sequencer;

    localparam logic [43:0] B_END  = 44'd1 << 43;
    localparam logic [43:0] B_JUMP = 44'd1 << 42;
    localparam logic [43:0] B_WAIT = 44'd1 << 41;
    localparam logic [43:0] B_HALT = 44'd1 << 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [43:0] cw = '0;
    logic [7:0]  ir_opcode = '0;
    logic        mem_ready = 1'b1;
    logic        irq = 1'b0;
    logic        int_en = 1'b0;
    logic        resume = 1'b0;
    logic [9:0]  addr;
    logic        cw_valid;
    logic        instr_done;
    logic        irq_ack;
    logic        halted;
    logic        fault;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 = prime, 1 = run, 2 = halted; m_addr = page*4+step.
    int m_mode;
    int m_addr;
    int m_fault;
    int e_addr, e_valid, e_done, e_ack, e_halt;
    int n_mode, n_fault;

    microcode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cw         (cw),
        .ir_opcode  (ir_opcode),
        .mem_ready  (mem_ready),
        .irq        (irq),
        .int_en     (int_en),
        .resume     (resume),
        .addr       (addr),
        .cw_valid   (cw_valid),
        .instr_done (instr_done),
        .irq_ack    (irq_ack),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic predict();
        int pg;
        int st;
        pg = m_addr / 4;
        st = m_addr % 4;
        e_addr  = m_addr;
        e_valid = 0;
        e_done  = 0;
        e_ack   = 0;
        e_halt  = (m_mode == 2) ? 1 : 0;
        n_mode  = m_mode;
        n_fault = m_fault;
        if (m_mode == 0) begin
            e_addr = 0;
            n_mode = 1;
        end else if (m_mode == 2) begin
            if (resume) begin
                e_addr = 0;
                n_mode = 1;
            end
        end else if (!(cw[41] && !mem_ready)) begin
            e_valid = 1;
            if (cw[40]) begin
                n_mode = 2;
            end else if (cw[43]) begin
                if (pg == 0) begin
                    if (ir_opcode == 8'h00 || ir_opcode >= 8'hFE) begin
                        e_addr  = 255 * 4;
                        n_fault = 1;
                    end else begin
                        e_addr = int'(ir_opcode) * 4;
                    end
                end else begin
                    e_done = 1;
                    if (irq && int_en) begin
                        e_addr = 254 * 4;
                        e_ack  = 1;
                    end else begin
                        e_addr = 0;
                    end
                end
            end else if (cw[42]) begin
                e_addr = int'(cw[7:0]) * 4;
            end else if (st == 3) begin
                e_addr  = 255 * 4;
                n_fault = 1;
            end else begin
                e_addr = m_addr + 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".addr"}, 32'(addr), e_addr);
        chk({tag, ".cw_valid"}, 32'(cw_valid), e_valid);
        chk({tag, ".instr_done"}, 32'(instr_done), e_done);
        chk({tag, ".irq_ack"}, 32'(irq_ack), e_ack);
        chk({tag, ".halted"}, 32'(halted), e_halt);
        chk({tag, ".fault"}, 32'(fault), m_fault);
    endtask

    // Entered and left at posedge+1.
    task automatic step(string tag, logic [43:0] w, logic [7:0] op,
                        bit mr, bit iq, bit ie, bit rs);
        cw = w;
        ir_opcode = op;
        mem_ready = mr;
        irq = iq;
        int_en = ie;
        resume = rs;
        #3;
        predict();
        check_all(tag);
        @(posedge clk);
        #1;
        m_mode  = n_mode;
        m_addr  = e_addr;
        m_fault = n_fault;
    endtask

    task automatic do_reset(string tag);
        rst = 1'b0;
        #1;
        m_mode  = 0;
        m_addr  = 0;
        m_fault = 0;
        predict();
        check_all(tag);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_fetch(logic [7:0] op);
        step("fetch0", '0, op, 1, 0, 0, 0);
        step("fetch1", B_END, op, 1, 0, 0, 0);
    endtask

    initial begin
        logic [43:0] w;
        do_reset("reset");
        step("prime", '0, 8'h00, 1, 0, 0, 0);
        chk("prime_done", 32'(m_mode), 1);
        // Dispatch to 0x12, stall, retire at step 2.
        run_fetch(8'h12);
        chk("dispatch_addr", 32'(m_addr), 32'h048);
        step("p12s0", '0, 8'h00, 1, 0, 0, 0);
        repeat (3) step("stall", B_WAIT, 8'h00, 0, 0, 0, 0);
        step("stall_go", B_WAIT, 8'h00, 1, 0, 0, 0);
        chk("after_stall", 32'(m_addr), 32'h04A);
        step("retire", B_END, 8'h00, 1, 0, 0, 0);
        chk("retired", 32'(m_addr), 32'h000);
        // Jump to 0x80 then run off the end of the page.
        run_fetch(8'h12);
        repeat (3) step("p12", '0, 8'h00, 1, 0, 0, 0);
        step("jump", B_JUMP | 44'h80, 8'h00, 1, 0, 0, 0);
        chk("jump_addr", 32'(m_addr), 32'h200);
        repeat (4) step("p80", '0, 8'h00, 1, 0, 0, 0);
        chk("overflow_addr", 32'(m_addr), 32'h3FC);
        step("trap0", B_END, 8'h00, 1, 0, 0, 0);
        // Interrupt taken, then masked.
        run_fetch(8'h12);
        step("irq_end", B_END | B_JUMP | 44'h55, 8'h00, 1, 1, 1, 0);
        chk("irq_addr", 32'(m_addr), 32'h3F8);
        step("irq_page", B_END, 8'h00, 1, 0, 0, 0);
        run_fetch(8'h12);
        step("masked", B_END, 8'h00, 1, 1, 0, 0);
        chk("masked_addr", 32'(m_addr), 32'h000);
        // Halt, resume, halt again and reset while halted.
        run_fetch(8'h12);
        step("p12s0", '0, 8'h00, 1, 0, 0, 0);
        step("halt", B_HALT | B_END, 8'h00, 1, 1, 1, 0);
        repeat (2) step("halted", B_END, 8'h00, 1, 1, 1, 0);
        step("resume", '0, 8'h00, 1, 0, 0, 1);
        step("post_resume", '0, 8'h00, 1, 0, 0, 0);
        step("halt2", B_HALT, 8'h00, 1, 0, 0, 0);
        do_reset("rst_halted");
        step("prime2", '0, 8'h00, 1, 0, 0, 0);
        // Illegal dispatch traps with a fresh fault flag.
        run_fetch(8'hFE);
        chk("illegal_addr", 32'(m_addr), 32'h3FC);
        step("illegal_flag", '0, 8'h00, 1, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset("rnd_reset");
            end
            w = {$urandom, $urandom};
            w[43] = ($urandom_range(0, 3) == 0);
            w[42] = ($urandom_range(0, 5) == 0);
            w[41] = ($urandom_range(0, 4) == 0);
            w[40] = ($urandom_range(0, 15) == 0);
            step("rnd", w, 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
